prog_loader_mb: RTL

- Parametrised successor to the single-bank ICCM programming controller.
- Consumes a framed byte stream from the programming UART receiver and assembles little-endian words of configurable width.
- Writes each word into one of NUM_BANKS memory banks (bank 0 = ICCM, bank 1 = DCCM, ...) and holds the system in reset while programming.
- Adds what the old controller lacked: a header carrying bank/address/length, a trailing checksum, an inter-byte timeout and error reporting.

---
 rtl/prog_loader_mb.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/prog_loader_mb.sv
// prog_loader_mb: framed UART byte stream loader writing little-endian words into one of
// NUM_BANKS memories, holding the system in reset while programming.
module prog_loader_mb #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 12,
    parameter int NUM_BANKS   = 2,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 prog_i,
    input  logic                 rx_valid_i,
    input  logic [7:0]           rx_byte_i,
    output logic [NUM_BANKS-1:0] bank_we_o,
    output logic [ADDR_W-1:0]    addr_o,
    output logic [DATA_W-1:0]    wdata_o,
    output logic                 sys_rst_no,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [1:0]           err_code_o
);
    localparam int BPW = DATA_W / 8;
    localparam int BW  = BPW > 1 ? $clog2(BPW) : 1;
    localparam int TW  = $clog2(TIMEOUT_CYC);

    typedef enum logic [2:0] {IDLE, HDR, DATA, CSUM, DONE, ERR} state_t;

    state_t                state_q;
    logic [7:0]            bank_q, acc_q;
    logic [2:0]            cnt_q;
    logic [BW-1:0]         bcnt_q;
    logic [15:0]           widx_q;
    logic [31:0]           hdr_q;
    logic [DATA_W-1:0]     word_q, wdata_q;
    logic [TW-1:0]         tmo_q;
    logic [NUM_BANKS-1:0]  we_q;
    logic [ADDR_W-1:0]     addr_q;
    logic                  sys_rst_q, done_q, err_q;
    logic [1:0]            code_q;
    logic [31:0]           hdr_d;
    logic [DATA_W-1:0]     word_d;
    logic                  busy, tmo_hit;

    // header bytes 1..4 shift in as {len_hi, len_lo, addr_hi, addr_lo}
    assign hdr_d   = {rx_byte_i, hdr_q[31:8]};
    assign word_d  = DATA_W'({rx_byte_i, word_q} >> 8);
    assign busy    = state_q == HDR || state_q == DATA || state_q == CSUM;
    assign tmo_hit = !rx_valid_i && tmo_q == TW'(TIMEOUT_CYC - 1);

    assign bank_we_o  = we_q;
    assign addr_o     = addr_q;
    assign wdata_o    = wdata_q;
    assign sys_rst_no = sys_rst_q;
    assign busy_o     = busy;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign err_code_o = code_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            bank_q    <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            bcnt_q    <= '0;
            widx_q    <= '0;
            hdr_q     <= '0;
            word_q    <= '0;
            wdata_q   <= '0;
            tmo_q     <= '0;
            we_q      <= '0;
            addr_q    <= '0;
            sys_rst_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            code_q    <= 2'b00;
        end else begin
            we_q      <= '0;
            sys_rst_q <= state_q == IDLE && !prog_i;
            tmo_q     <= (rx_valid_i || !busy) ? '0 : tmo_q + 1'b1;
            // abort and timeout take priority over any byte in the same cycle
            if (busy && (!prog_i || tmo_hit)) begin
                state_q <= ERR;
                err_q   <= 1'b1;
                code_q  <= 2'b11;
            end else begin
                case (state_q)
                    IDLE: if (prog_i) begin
                        state_q <= HDR;
                        done_q  <= 1'b0;
                        err_q   <= 1'b0;
                        code_q  <= 2'b00;
                        cnt_q   <= '0;
                        bcnt_q  <= '0;
                        widx_q  <= '0;
                        acc_q   <= '0;
                    end
                    HDR: if (rx_valid_i) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == 3'd0) begin
                            bank_q <= rx_byte_i;
                            if (rx_byte_i >= 8'(NUM_BANKS)) begin
                                state_q <= ERR;
                                err_q   <= 1'b1;
                                code_q  <= 2'b01;
                            end
                        end else begin
                            hdr_q <= hdr_d;
                            if (cnt_q == 3'd4)
                                state_q <= hdr_d[31:16] == 16'd0 ? CSUM : DATA;
                        end
                    end
                    DATA: if (rx_valid_i) begin
                        acc_q  <= acc_q + rx_byte_i;
                        word_q <= word_d;
                        bcnt_q <= bcnt_q + 1'b1;
                        if (bcnt_q == BW'(BPW - 1)) begin
                            bcnt_q  <= '0;
                            we_q    <= NUM_BANKS'(1) << bank_q;
                            addr_q  <= ADDR_W'(hdr_q[15:0] + widx_q);
                            wdata_q <= word_d;
                            widx_q  <= widx_q + 16'd1;
                            if (widx_q == hdr_q[31:16] - 16'd1) state_q <= CSUM;
                        end
                    end
                    CSUM: if (rx_valid_i) begin
                        if (8'(acc_q + rx_byte_i) == 8'd0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ERR;
                            err_q   <= 1'b1;
                            code_q  <= 2'b10;
                        end
                    end
                    DONE, ERR: if (!prog_i) state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
endmodule
